// File: rtl/mopshub_test_sequencer.sv
// Test-phase sequencer for the 16-bus MOPSHUB testbench environment.
// Steps sign-on, RX, end-wait, gap, TX iterations and advanced phase, with a per-phase watchdog.
module mopshub_test_sequencer #(
    parameter int RUN_RX         = 1,
    parameter int GAP_CYCLES     = 120,
    parameter int MAX_TX_ITER    = 0,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int ITER_W         = 16
) (
    input  logic              clk_40_m,
    input  logic              rst,
    input  logic              enable,
    input  logic              adv_req,
    input  logic              sign_on_sig,
    input  logic              end_power_init,
    input  logic              test_rx_end,
    input  logic              test_tx_end,
    input  logic              test_advanced_end,
    output logic              test_rx,
    output logic              test_tx,
    output logic              test_advanced,
    output logic              endwait_all,
    output logic              osc_trim_clr,
    output logic [ITER_W-1:0] tx_iter_cnt,
    output logic              timeout_err,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_SIGNON = 3'd1,
        RX          = 3'd2,
        ENDWAIT     = 3'd3,
        GAP         = 3'd4,
        TX          = 3'd5,
        ADV         = 3'd6,
        DONE        = 3'd7
    } state_t;

    localparam int                GAP_EFF    = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int                GAP_W      = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD   = GAP_W'(GAP_EFF - 1);
    localparam logic [17:0]       TIMEOUT_V  = 18'(TIMEOUT_CYCLES);
    localparam logic [ITER_W-1:0] MAX_ITER_V = ITER_W'(MAX_TX_ITER);
    localparam bit                LIMITED    = (MAX_TX_ITER != 0);

    // Handshake: a phase request (test_rx/test_tx/test_advanced) is a level held for the whole
    // phase; the environment answers with a one-cycle *_end pulse, which is only honoured while
    // the sequencer sits in the matching state. Strays in other states are dropped.

    state_t            state, next_state;
    logic [GAP_W-1:0]  gap_cnt;
    logic [17:0]       wdog_cnt;
    logic              epi_q;
    logic              wdog_hit, wdog_clr, wdog_run;
    logic              tx_inc, set_timeout, run_start;
    logic [ITER_W-1:0] tx_cnt_inc;
    logic              rx_d, tx_d, adv_d, endwait_d, busy_d;

    assign state_dbg  = state;
    assign wdog_hit   = ({1'b0, wdog_cnt} + 19'd1) >= {1'b0, TIMEOUT_V};
    assign wdog_run   = (state == RX) || (state == TX) || (state == ADV);
    assign tx_cnt_inc = (tx_iter_cnt == '1) ? tx_iter_cnt : tx_iter_cnt + ITER_W'(1);
    assign run_start  = (state == IDLE) && (next_state == WAIT_SIGNON);

    always_ff @(posedge clk_40_m) begin
        if (!rst) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            wdog_cnt      <= '0;
            epi_q         <= 1'b0;
            osc_trim_clr  <= 1'b0;
            tx_iter_cnt   <= '0;
            timeout_err   <= 1'b0;
            test_rx       <= 1'b0;
            test_tx       <= 1'b0;
            test_advanced <= 1'b0;
            endwait_all   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state        <= next_state;
            epi_q        <= end_power_init;
            osc_trim_clr <= end_power_init & ~epi_q;

            if (next_state == GAP && state != GAP)
                gap_cnt <= GAP_LOAD;
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - GAP_W'(1);

            if (wdog_clr)
                wdog_cnt <= '0;
            else if (wdog_run)
                wdog_cnt <= wdog_cnt + 18'd1;

            if (run_start) begin
                tx_iter_cnt <= '0;
                timeout_err <= 1'b0;
            end else begin
                if (tx_inc)
                    tx_iter_cnt <= tx_cnt_inc;
                if (set_timeout)
                    timeout_err <= 1'b1;
            end

            test_rx       <= rx_d;
            test_tx       <= tx_d;
            test_advanced <= adv_d;
            endwait_all   <= endwait_d;
            busy          <= busy_d;
        end
    end

    // enable low overrides everything, including a watchdog expiry in the same cycle.
    always_comb begin
        next_state  = state;
        tx_inc      = 1'b0;
        set_timeout = 1'b0;
        wdog_clr    = 1'b0;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:        next_state = WAIT_SIGNON;
                WAIT_SIGNON: if (sign_on_sig) next_state = (RUN_RX != 0) ? RX : TX;
                RX: begin
                    if (test_rx_end) begin
                        next_state = ENDWAIT;
                        wdog_clr   = 1'b1;
                    end else if (wdog_hit) begin
                        next_state  = DONE;
                        set_timeout = 1'b1;
                    end
                end
                ENDWAIT:     next_state = GAP;
                GAP:         if (gap_cnt == '0) next_state = TX;
                TX: begin
                    if (test_tx_end) begin
                        tx_inc   = 1'b1;
                        wdog_clr = 1'b1;
                        if (LIMITED && tx_cnt_inc == MAX_ITER_V)
                            next_state = adv_req ? ADV : DONE;
                    end else if (wdog_hit) begin
                        next_state  = DONE;
                        set_timeout = 1'b1;
                    end
                end
                ADV: begin
                    if (test_advanced_end) begin
                        next_state = DONE;
                        wdog_clr   = 1'b1;
                    end else if (wdog_hit) begin
                        next_state  = DONE;
                        set_timeout = 1'b1;
                    end
                end
                DONE:        next_state = DONE;
                default:     next_state = IDLE;
            endcase
        end
        if (next_state != state)
            wdog_clr = 1'b1;
    end

    // Outputs are decoded from next_state and registered, so they line up with state_dbg.
    always_comb begin
        rx_d      = (next_state == RX);
        tx_d      = (next_state == TX);
        adv_d     = (next_state == ADV);
        endwait_d = (next_state == ENDWAIT);
        busy_d    = (next_state != IDLE) && (next_state != DONE);
    end

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// Bench for mopshub_test_sequencer: directed phase walk-through plus randomized traffic
// checked every cycle against a phase-level model of the sequencer.
module tb_mopshub_test_sequencer;

    localparam int P_RUN_RX  = 1;
    localparam int P_GAP     = 120;
    localparam int P_MAX     = 3;
    localparam int P_TIMEOUT = 1000;
    localparam int P_ITER_W  = 16;
    localparam int ITER_MAX  = (1 << P_ITER_W) - 1;

    logic                clk_40_m = 1'b0;
    logic                rst;
    logic                enable, adv_req, sign_on_sig, end_power_init;
    logic                test_rx_end, test_tx_end, test_advanced_end;
    logic                test_rx, test_tx, test_advanced, endwait_all, osc_trim_clr;
    logic [P_ITER_W-1:0] tx_iter_cnt;
    logic                timeout_err, busy;
    logic [2:0]          state_dbg;

    int  chk_total = 0;
    int  chk_pass  = 0;
    bit  check_en  = 1'b0;

    mopshub_test_sequencer #(
        .RUN_RX(P_RUN_RX), .GAP_CYCLES(P_GAP), .MAX_TX_ITER(P_MAX),
        .TIMEOUT_CYCLES(P_TIMEOUT), .ITER_W(P_ITER_W)
    ) dut (
        .clk_40_m(clk_40_m), .rst(rst), .enable(enable), .adv_req(adv_req),
        .sign_on_sig(sign_on_sig), .end_power_init(end_power_init),
        .test_rx_end(test_rx_end), .test_tx_end(test_tx_end),
        .test_advanced_end(test_advanced_end), .test_rx(test_rx), .test_tx(test_tx),
        .test_advanced(test_advanced), .endwait_all(endwait_all),
        .osc_trim_clr(osc_trim_clr), .tx_iter_cnt(tx_iter_cnt),
        .timeout_err(timeout_err), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #10 clk_40_m = ~clk_40_m;

    task automatic tick();
        @(posedge clk_40_m);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_total++;
        if (act === exp) chk_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Phase-level model: phase numbers follow the documented state encoding.
    int m_phase = 0, m_gap_left = 0, m_wd = 0, m_iter = 0;
    bit m_err = 0, m_epi_prev = 0, m_trim = 0;

    task automatic wd_tick();
        m_wd++;
        if (m_wd >= P_TIMEOUT) begin
            m_err   = 1;
            m_phase = 7;
        end
    endtask

    always @(posedge clk_40_m) begin
        if (!rst) begin
            m_phase = 0; m_gap_left = 0; m_wd = 0; m_iter = 0;
            m_err = 0; m_epi_prev = 0; m_trim = 0;
        end else begin
            m_trim     = end_power_init && !m_epi_prev;
            m_epi_prev = end_power_init;
            if (!enable) m_phase = 0;
            else begin
                case (m_phase)
                    0: begin m_phase = 1; m_iter = 0; m_err = 0; end
                    1: if (sign_on_sig) begin m_phase = (P_RUN_RX != 0) ? 2 : 5; m_wd = 0; end
                    2: if (test_rx_end) m_phase = 3; else wd_tick();
                    3: begin m_phase = 4; m_gap_left = (P_GAP < 1) ? 1 : P_GAP; end
                    4: begin
                        m_gap_left--;
                        if (m_gap_left == 0) begin m_phase = 5; m_wd = 0; end
                    end
                    5: if (test_tx_end) begin
                        m_iter = (m_iter == ITER_MAX) ? m_iter : m_iter + 1;
                        m_wd   = 0;
                        if (P_MAX != 0 && m_iter == P_MAX) m_phase = adv_req ? 6 : 7;
                    end else wd_tick();
                    6: if (test_advanced_end) m_phase = 7; else wd_tick();
                    default: ;
                endcase
            end
        end
    end

    // scoreboard: one compare per cycle, expected vector pushed and popped through exp_q
    logic [25:0] exp_q[$];
    always @(negedge clk_40_m) begin
        logic [25:0] act_v, exp_v;
        if (check_en) begin
            exp_q.push_back({m_phase == 2, m_phase == 5, m_phase == 6, m_phase == 3, m_trim,
                             (m_phase != 0 && m_phase != 7), m_err, 3'(m_phase),
                             P_ITER_W'(m_iter)});
            exp_v = exp_q.pop_front();
            act_v = {test_rx, test_tx, test_advanced, endwait_all, osc_trim_clr, busy,
                     timeout_err, state_dbg, tx_iter_cnt};
            chk_total++;
            if (act_v === exp_v) chk_pass++;
            else $display("FAIL cycle_outputs: got %07h expected %07h (t=%0t)", act_v, exp_v, $time);
        end
    end

    task automatic pulse_signon();
        sign_on_sig = 1; tick(); sign_on_sig = 0;
    endtask

    initial begin
        int n, pulses;
        bit quiet;
        rst = 0; enable = 1; adv_req = 0; sign_on_sig = 0; end_power_init = 0;
        test_rx_end = 0; test_tx_end = 0; test_advanced_end = 0;
        tick();
        check_en = 1;
        repeat (3) tick();
        check("reset_outputs", {test_rx, test_tx, test_advanced, endwait_all, osc_trim_clr,
                                busy, timeout_err, state_dbg, tx_iter_cnt}, 0);

        rst = 1; tick();
        check("wait_signon_state", state_dbg, 1);
        pulse_signon();
        check("rx_request", test_rx, 1);
        check("rx_state", state_dbg, 2);

        // stray tx end together with rx end: only the RX end counts
        test_rx_end = 1; test_tx_end = 1; tick(); test_rx_end = 0; test_tx_end = 0;
        check("endwait_pulse", endwait_all, 1);
        check("endwait_state", state_dbg, 3);
        check("stray_tx_iter", tx_iter_cnt, 0);
        tick();
        check("endwait_single", endwait_all, 0);
        n = 0;
        while (state_dbg == 4 && n < 300) begin n++; tick(); end
        check("gap_cycles", n, 120);
        check("tx_request", test_tx, 1);
        check("tx_state", state_dbg, 5);

        adv_req = 1;
        for (int i = 0; i < 3; i++) begin
            test_tx_end = 1; tick(); test_tx_end = 0;
            check("tx_iter_step", tx_iter_cnt, i + 1);
            tick();
        end
        check("tx_dropped", test_tx, 0);
        check("adv_request", test_advanced, 1);
        test_advanced_end = 1; tick(); test_advanced_end = 0;
        check("done_state", state_dbg, 7);
        check("done_busy", busy, 0);

        end_power_init = 1; pulses = 0;
        for (int i = 0; i < 8; i++) begin tick(); pulses += int'(osc_trim_clr); end
        check("osc_trim_pulses", pulses, 1);

        enable = 0; tick();
        check("disable_idle", state_dbg, 0);
        check("iter_held", tx_iter_cnt, 3);
        enable = 1; tick();
        check("iter_cleared", tx_iter_cnt, 0);

        // watchdog in TX
        pulse_signon();
        test_rx_end = 1; tick(); test_rx_end = 0;
        n = 0;
        while (state_dbg != 5 && n < 400) begin n++; tick(); end
        check("reach_tx", state_dbg, 5);
        n = 0;
        while (state_dbg == 5 && n < 2000) begin n++; tick(); end
        check("timeout_cycles", n, 1000);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_done", state_dbg, 7);
        check("timeout_reqs", {test_rx, test_tx, test_advanced}, 0);
        enable = 0; tick();
        check("err_held", timeout_err, 1);
        enable = 1; tick();
        check("err_cleared", timeout_err, 0);

        // enable dropped mid-gap
        pulse_signon();
        test_rx_end = 1; tick(); test_rx_end = 0;
        repeat (11) tick();
        check("in_gap", state_dbg, 4);
        enable = 0; tick();
        check("gap_abort_idle", state_dbg, 0);
        n = 0;
        for (int i = 0; i < 150; i++) begin tick(); n += int'(test_tx); end
        check("gap_abort_no_tx", n, 0);
        enable = 1;

        // randomized traffic, checked by the per-cycle scoreboard
        for (int blk = 0; blk < 8; blk++) begin
            quiet = (blk % 4 == 3);
            for (int c = 0; c < 2000; c++) begin
                enable            = ($urandom_range(0, 399) != 0);
                adv_req           = $urandom_range(0, 1) == 1;
                sign_on_sig       = $urandom_range(0, 7) == 0;
                test_rx_end       = !quiet && ($urandom_range(0, 29) == 0);
                test_tx_end       = !quiet && ($urandom_range(0, 29) == 0);
                test_advanced_end = !quiet && ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 49) == 0) end_power_init = ~end_power_init;
                if ($urandom_range(0, 4999) == 0) rst = 0; else rst = 1;
                tick();
            end
        end
        rst = 1;
        tick();
        check_en = 0;
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule
